cmi_mem_resp: RTL and testbench

CMI_MEM_RESP -- requirements
Module: cmi_mem_resp

---
 rtl/cmi_mem_resp_pkg.sv | 22 ++
 rtl/cmi_bpar_gen.sv | 9 +
 rtl/cmi_mem_resp.sv | 140 ++++++++++++++
 tb/tb_cmi_mem_resp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmi_mem_resp_pkg.sv
// cmi_mem_resp_pkg: shared ucode definitions (function, status and FSM codes) for the CMI memory responder
package cmi_mem_resp_pkg;
    typedef enum logic [3:0] {
        F_READ     = 4'h0,
        F_READ_LNG = 4'h1,
        F_READ_LCK = 4'h2,
        F_WRITE    = 4'h8,
        F_WRITE_UL = 4'h9
    } func_e;

    typedef enum logic [1:0] {ST_OK, ST_NXM, ST_LOCKED, ST_ERR} status_e;

    typedef enum logic [2:0] {IDLE, WDAT, MEMRD, MEMWR, RSP, RSP2} state_e;

    function automatic logic func_ok(input logic [3:0] f);
        return f inside {F_READ, F_READ_LNG, F_READ_LCK, F_WRITE, F_WRITE_UL};
    endfunction

    function automatic logic func_wr(input logic [3:0] f);
        return f == F_WRITE || f == F_WRITE_UL;
    endfunction
endpackage

// File: rtl/cmi_bpar_gen.sv
// cmi_bpar_gen: per-byte odd parity over a 32-bit longword
module cmi_bpar_gen (
    input  logic [31:0] data_h,
    output logic [3:0]  par_h
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign par_h[i] = ~^data_h[8*i +: 8];
    end
endmodule

// File: rtl/cmi_mem_resp.sv
// cmi_mem_resp: CMI memory command responder with lock, timeout and DMA cache invalidate
module cmi_mem_resp
    import cmi_mem_resp_pkg::*;
#(
    parameter logic [21:0] MEM_TOP = 22'h0FFFFF,
    parameter int          TIMEOUT = 15
) (
    input  logic        b_clk_l,
    input  logic        init_l,
    input  logic        cmd_valid_h,
    input  logic [3:0]  cmd_func_h,
    input  logic [21:0] cmd_addr_h,
    input  logic [3:0]  cmd_mask_h,
    input  logic        cmd_dma_h,
    output logic        cmd_ready_h,
    input  logic        wdata_valid_h,
    input  logic [31:0] wdata_h,
    output logic        status_valid_l,
    output logic [1:0]  status_h,
    output logic [31:0] rdata_h,
    output logic [3:0]  rdata_par_h,
    output logic        mem_req_h,
    output logic        mem_we_h,
    output logic [21:0] mem_addr_h,
    output logic [3:0]  mem_be_h,
    output logic [31:0] mem_wdata_h,
    input  logic [31:0] mem_rdata_h,
    input  logic        mem_ack_h,
    output logic        inval_req_h,
    output logic [21:0] inval_addr_h
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state, state_nxt;
    status_e     st_q, st_nxt;
    logic        run_q, dma_q, lock_q, second_q;
    logic [3:0]  func_q, mask_q, par;
    logic [21:0] addr_q, addr_inc;
    logic [31:0] wd_q, rd_q;
    logic [7:0]  tmo_q;
    logic        accept, rsp, lng_next, tmo_hit, inval_hit;

    cmi_bpar_gen u_par (.data_h(rd_q), .par_h(par));

    assign cmd_ready_h = run_q && state == IDLE;
    assign accept      = cmd_valid_h && cmd_ready_h;
    assign mem_req_h   = state == MEMRD || state == MEMWR;
    assign mem_we_h    = state == MEMWR;
    assign mem_be_h    = state == MEMRD ? 4'hF : state == MEMWR ? mask_q : 4'h0;
    assign mem_addr_h  = addr_q;
    assign mem_wdata_h = wd_q;
    assign addr_inc    = addr_q + 22'd1;
    assign rsp         = state == RSP || state == RSP2;
    assign lng_next    = state == RSP && func_q == F_READ_LNG && !second_q;
    assign tmo_hit     = tmo_q == TMO_LAST;
    assign inval_hit   = rsp && func_wr(func_q) && dma_q && st_q == ST_OK;

    always_comb begin
        state_nxt = state;
        st_nxt    = st_q;
        case (state)
            IDLE: if (accept) begin
                st_nxt    = !func_ok(cmd_func_h) ? ST_ERR :
                            (cmd_func_h == F_READ_LCK && lock_q) ? ST_LOCKED :
                            (cmd_addr_h > MEM_TOP) ? ST_NXM : ST_OK;
                state_nxt = (st_nxt == ST_ERR || st_nxt == ST_LOCKED) ? RSP :
                            func_wr(cmd_func_h) ? WDAT :
                            (st_nxt == ST_NXM) ? RSP : MEMRD;
            end
            WDAT: if (wdata_valid_h) state_nxt = (st_q != ST_OK || mask_q == 4'h0) ? RSP : MEMWR;
            MEMRD: if (mem_ack_h || tmo_hit) begin
                state_nxt = second_q ? RSP2 : RSP;
                st_nxt    = mem_ack_h ? st_q : ST_NXM;
            end
            MEMWR: if (mem_ack_h || tmo_hit) begin
                state_nxt = RSP;
                st_nxt    = mem_ack_h ? st_q : ST_NXM;
            end
            RSP: if (lng_next) begin
                st_nxt    = (addr_inc > MEM_TOP || addr_inc == 22'd0) ? ST_NXM : ST_OK;
                state_nxt = st_nxt == ST_NXM ? RSP2 : MEMRD;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response outputs are registered one edge after RSP/RSP2 so the strobe, data and parity align
    always_ff @(posedge b_clk_l or negedge init_l) begin
        if (!init_l) begin
            state          <= IDLE;
            st_q           <= ST_OK;
            run_q          <= 1'b0;
            func_q         <= '0;
            addr_q         <= '0;
            mask_q         <= '0;
            dma_q          <= 1'b0;
            wd_q           <= '0;
            rd_q           <= '0;
            lock_q         <= 1'b0;
            second_q       <= 1'b0;
            tmo_q          <= '0;
            status_valid_l <= 1'b1;
            status_h       <= '0;
            rdata_h        <= '0;
            rdata_par_h    <= '0;
            inval_req_h    <= 1'b0;
            inval_addr_h   <= '0;
        end else begin
            state          <= state_nxt;
            st_q           <= st_nxt;
            run_q          <= 1'b1;
            tmo_q          <= (mem_req_h && !mem_ack_h) ? tmo_q + 8'd1 : 8'd0;
            status_valid_l <= !rsp;
            inval_req_h    <= inval_hit;
            if (accept) begin
                func_q   <= cmd_func_h;
                addr_q   <= cmd_addr_h;
                mask_q   <= cmd_mask_h;
                dma_q    <= cmd_dma_h;
                second_q <= 1'b0;
            end
            if (state == WDAT && wdata_valid_h) wd_q <= wdata_h;
            if (state == MEMRD && mem_ack_h) rd_q <= mem_rdata_h;
            if (lng_next) begin
                second_q <= 1'b1;
                addr_q   <= addr_inc;
            end
            if (rsp) begin
                status_h    <= st_q;
                rdata_h     <= rd_q;
                rdata_par_h <= par;
            end
            if (inval_hit) inval_addr_h <= addr_q;
            if (state == RSP && func_q == F_READ_LCK && st_q == ST_OK) lock_q <= 1'b1;
            else if (state == RSP && func_q == F_WRITE_UL) lock_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cmi_mem_resp.sv
// tb_cmi_mem_resp: directed scoreboard bench for cmi_mem_resp
module tb_cmi_mem_resp;
    import cmi_mem_resp_pkg::*;

    logic        b_clk_l = 1'b0;
    logic        init_l = 1'b1;
    logic        cmd_valid_h = 1'b0, cmd_dma_h = 1'b0, wdata_valid_h = 1'b0, mem_ack_h = 1'b0;
    logic [3:0]  cmd_func_h = '0, cmd_mask_h = '0;
    logic [21:0] cmd_addr_h = '0;
    logic [31:0] wdata_h = '0, mem_rdata_h = '0;
    logic        cmd_ready_h, status_valid_l, mem_req_h, mem_we_h, inval_req_h;
    logic [1:0]  status_h;
    logic [31:0] rdata_h, mem_wdata_h;
    logic [3:0]  rdata_par_h, mem_be_h;
    logic [21:0] mem_addr_h, inval_addr_h;

    typedef struct {
        logic [1:0]  st;
        bit          cd;
        logic [31:0] d;
        logic [3:0]  p;
        bit          inv;
        logic [21:0] ia;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, passed = 0;
    time         acc_t;
    bit          ack_en = 1'b1;
    int          acks = 0, req_cyc = 0;
    logic        last_we;
    logic [3:0]  last_be;
    logic [21:0] last_addr;
    logic [31:0] last_wdata;

    always #5 b_clk_l = ~b_clk_l;

    cmi_mem_resp dut (
        .b_clk_l(b_clk_l), .init_l(init_l),
        .cmd_valid_h(cmd_valid_h), .cmd_func_h(cmd_func_h), .cmd_addr_h(cmd_addr_h),
        .cmd_mask_h(cmd_mask_h), .cmd_dma_h(cmd_dma_h), .cmd_ready_h(cmd_ready_h),
        .wdata_valid_h(wdata_valid_h), .wdata_h(wdata_h),
        .status_valid_l(status_valid_l), .status_h(status_h),
        .rdata_h(rdata_h), .rdata_par_h(rdata_par_h),
        .mem_req_h(mem_req_h), .mem_we_h(mem_we_h), .mem_addr_h(mem_addr_h),
        .mem_be_h(mem_be_h), .mem_wdata_h(mem_wdata_h), .mem_rdata_h(mem_rdata_h),
        .mem_ack_h(mem_ack_h), .inval_req_h(inval_req_h), .inval_addr_h(inval_addr_h)
    );

    function automatic logic [31:0] mdata(input logic [21:0] a);
        return a == 22'h10 ? 32'h12345678 : {10'h2A5, a};
    endfunction

    function automatic logic [3:0] opar(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ~^d[8*i +: 8];
        return p;
    endfunction

    function automatic exp_t mk(input logic [1:0] st, input bit cd, input logic [31:0] d,
                                input logic [3:0] p, input bit inv, input logic [21:0] ia, input int lat);
        exp_t e;
        e.st = st; e.cd = cd; e.d = d; e.p = p; e.inv = inv; e.ia = ia; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t rd_ok(input logic [21:0] a);
        return mk(ST_OK, 1, mdata(a), opar(mdata(a)), 0, 0, 0);
    endfunction

    function automatic exp_t plain(input logic [1:0] st);
        return mk(st, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h", n, act, req);
    endfunction

    // storage model: acks every request in its first cycle unless ack_en is cleared
    initial forever begin
        @(posedge b_clk_l);
        #1;
        mem_ack_h = 1'b0;
        if (mem_req_h) begin
            req_cyc++;
            if (ack_en) begin
                mem_ack_h   = 1'b1;
                mem_rdata_h = mdata(mem_addr_h);
                acks++;
                last_we = mem_we_h; last_be = mem_be_h;
                last_addr = mem_addr_h; last_wdata = mem_wdata_h;
            end
        end
    end

    always @(negedge b_clk_l) begin
        if (init_l && !status_valid_l) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: got status %0d want no response", status_h);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("status", 32'(status_h), 32'(e.st));
                if (e.cd) begin
                    chk("rdata", rdata_h, e.d);
                    chk("rdata_par", 32'(rdata_par_h), 32'(e.p));
                end
                chk("inval_req", 32'(inval_req_h), 32'(e.inv));
                if (e.inv) chk("inval_addr", 32'(inval_addr_h), 32'(e.ia));
                if (e.lat > 0) chk("latency", 32'($time - acc_t), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] f, input logic [21:0] a, input logic [3:0] m,
                         input logic d, input logic [31:0] wd);
        int n = 0;
        while (!cmd_ready_h && n < 50) begin
            @(posedge b_clk_l);
            #1;
            n++;
        end
        if (!cmd_ready_h) begin
            checks++;
            $display("FAIL cmd_ready_wait: got 0 want 1");
            return;
        end
        cmd_valid_h = 1'b1; cmd_func_h = f; cmd_addr_h = a; cmd_mask_h = m; cmd_dma_h = d;
        @(posedge b_clk_l);
        acc_t = $time;
        #1;
        cmd_valid_h = 1'b0;
        if (func_wr(f)) begin
            wdata_valid_h = 1'b1;
            wdata_h = wd;
            @(posedge b_clk_l);
            #1;
            wdata_valid_h = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge b_clk_l);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d responses missing want 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(posedge b_clk_l);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #2 init_l = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_h), 0);
        chk("rst_status_valid_l", 32'(status_valid_l), 1);
        chk("rst_mem_req", 32'(mem_req_h), 0);
        chk("rst_status", 32'(status_h), 0);
        chk("rst_rdata", rdata_h, 0);
        chk("rst_rdata_par", 32'(rdata_par_h), 0);
        chk("rst_inval", 32'(inval_req_h), 0);
        @(negedge b_clk_l);
        @(negedge b_clk_l);
        init_l = 1'b1;
        @(posedge b_clk_l);
        #1;
        chk("cmd_ready_after_rst", 32'(cmd_ready_h), 1);

        acks = 0;
        sbq.push_back(mk(ST_OK, 1, 32'h12345678, 4'b1011, 0, 0, 25));
        issue(F_READ, 22'h10, 4'h0, 0, 0);
        drain();
        chk("read_acks", acks, 1);
        chk("read_we", 32'(last_we), 0);
        chk("read_be", 32'(last_be), 32'hF);

        acks = 0;
        sbq.push_back(mk(ST_OK, 0, 0, 0, 1, 22'h20, 0));
        issue(F_WRITE, 22'h20, 4'b0110, 1, 32'hAABBCCDD);
        drain();
        chk("write_acks", acks, 1);
        chk("write_we", 32'(last_we), 1);
        chk("write_be", 32'(last_be), 32'h6);
        chk("write_addr", 32'(last_addr), 32'h20);
        chk("write_wdata", last_wdata, 32'hAABBCCDD);

        acks = 0;
        sbq.push_back(rd_ok(22'h100));
        sbq.push_back(rd_ok(22'h101));
        issue(F_READ_LNG, 22'h100, 4'h0, 0, 0);
        drain();
        chk("lng_acks", acks, 2);
        chk("lng_addr2", 32'(last_addr), 32'h101);

        acks = 0;
        sbq.push_back(rd_ok(22'h0FFFFF));
        sbq.push_back(plain(ST_NXM));
        issue(F_READ_LNG, 22'h0FFFFF, 4'h0, 0, 0);
        drain();
        chk("lng_top_acks", acks, 1);

        acks = 0;
        sbq.push_back(plain(ST_NXM));
        issue(F_READ, 22'h100000, 4'h0, 0, 0);
        sbq.push_back(plain(ST_NXM));
        issue(F_WRITE, 22'h200000, 4'hF, 1, 32'h55555555);
        sbq.push_back(plain(ST_ERR));
        issue(4'h5, 22'h10, 4'h0, 0, 0);
        sbq.push_back(plain(ST_OK));
        issue(F_WRITE, 22'h30, 4'h0, 0, 32'h01020304);
        drain();
        chk("nxm_err_mask0_acks", acks, 0);

        acks = 0;
        sbq.push_back(rd_ok(22'h40));
        issue(F_READ_LCK, 22'h40, 4'h0, 0, 0);
        sbq.push_back(plain(ST_LOCKED));
        issue(F_READ_LCK, 22'h40, 4'h0, 0, 0);
        sbq.push_back(plain(ST_OK));
        issue(F_WRITE_UL, 22'h40, 4'hF, 0, 32'h2A500040);
        sbq.push_back(rd_ok(22'h40));
        issue(F_READ_LCK, 22'h40, 4'h0, 0, 0);
        drain();
        chk("lock_acks", acks, 3);

        acks = 0; req_cyc = 0; ack_en = 1'b0;
        sbq.push_back(plain(ST_NXM));
        issue(F_READ, 22'h50, 4'h0, 0, 0);
        drain();
        chk("timeout_req_cycles", req_cyc, 15);

        issue(F_WRITE, 22'h30, 4'hF, 1, 32'h11223344);
        chk("memwr_req", 32'(mem_req_h), 1);
        @(negedge b_clk_l);
        init_l = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req_h), 0);
        chk("abort_cmd_ready", 32'(cmd_ready_h), 0);
        chk("abort_status_valid_l", 32'(status_valid_l), 1);
        @(negedge b_clk_l);
        @(negedge b_clk_l);
        init_l = 1'b1;
        ack_en = 1'b1;
        @(posedge b_clk_l);
        #1;
        chk("abort_cmd_ready_release", 32'(cmd_ready_h), 1);

        acks = 0;
        sbq.push_back(rd_ok(22'h60));
        issue(F_READ_LCK, 22'h60, 4'h0, 0, 0);
        drain();
        chk("post_rst_acks", acks, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
